// File: rtl/wave_seq_pkg.sv
// wave_seq_pkg: shared shape codes, segment-entry field layout and sequencer state encoding.
// Entry layout (ENTRY_W = 50): [49:48] shape, [47:32] frequency code,
// [31:24] amplitude %, [23:16] duty %, [15:0] dwell in ms.
package wave_seq_pkg;
  localparam int ENTRY_W   = 50;
  localparam int SHAPE_LSB = 48;
  localparam int SHAPE_W   = 2;
  localparam int FREQ_LSB  = 32;
  localparam int FREQ_W    = 16;
  localparam int AMP_LSB   = 24;
  localparam int AMP_W     = 8;
  localparam int DUTY_LSB  = 16;
  localparam int DUTY_W    = 8;
  localparam int DWELL_LSB = 0;
  localparam int DWELL_W   = 16;
  typedef enum logic [1:0] {
    SH_OFF  = 2'd0,
    SH_RECT = 2'd1,
    SH_SAW  = 2'd2,
    SH_TRI  = 2'd3
  } shape_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/ms_prescaler.sv
// ms_prescaler: divides clk down to a one-cycle tick every CLK_PER_MS enabled cycles.
// Ports: clk, rst_n (async, active low); clr forces the count to 0;
// en advances the count; tick is high on the last enabled cycle of each ms.
module ms_prescaler #(
  parameter int CLK_PER_MS = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = CLK_PER_MS > 1 ? $clog2(CLK_PER_MS) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(CLK_PER_MS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
endmodule

// File: rtl/wave_sequencer.sv
// wave_sequencer: plays a programmable table of waveform segments onto the rect/saw/tri generators.
// Ports: clk, rst_n (async, active low); wr_en/wr_addr/wr_data write one table entry;
// num_entries (sampled at start) and loop_en (live) shape playback; start/stop are
// single-cycle requests. Outputs: one-hot-or-zero generator enables on_rect/on_saw/on_tri,
// registered config frequency/amplitude/duty_cycle, cur_index, busy (LOAD or RUN) and a
// one-cycle done pulse at the end of a non-looping sequence.
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter  int DEPTH      = 8,
  parameter  int CLK_PER_MS = 100000,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [AW:0]        num_entries,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  output logic               on_rect,
  output logic               on_saw,
  output logic               on_tri,
  output logic [15:0]        frequency,
  output logic [7:0]         amplitude,
  output logic [7:0]         duty_cycle,
  output logic [AW-1:0]      cur_index,
  output logic               busy,
  output logic               done
);
  logic [ENTRY_W-1:0] tbl [DEPTH];
  state_e             state;
  logic [AW-1:0]      idx;
  logic [AW:0]        cnt;
  logic [15:0]        dwell;
  logic               tick;
  logic [ENTRY_W-1:0] ent;
  shape_e             shape;
  logic [15:0]        ent_dwell;
  assign ent       = tbl[idx];
  assign shape     = shape_e'(ent[SHAPE_LSB +: SHAPE_W]);
  assign ent_dwell = ent[DWELL_LSB +: DWELL_W];
  // The prescaler only runs in RUN and restarts from 0 every time a segment loads,
  // so each segment's on-time is exactly dwell * CLK_PER_MS cycles.
  ms_prescaler #(.CLK_PER_MS(CLK_PER_MS)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != S_RUN),
    .en   (state == S_RUN),
    .tick (tick)
  );
  // Nonblocking update means a LOAD on the written address still reads the old entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      dwell      <= '0;
      on_rect    <= 1'b0;
      on_saw     <= 1'b0;
      on_tri     <= 1'b0;
      frequency  <= '0;
      amplitude  <= '0;
      duty_cycle <= '0;
      cur_index  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state   <= S_IDLE;
        on_rect <= 1'b0;
        on_saw  <= 1'b0;
        on_tri  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_IDLE:
            if (start && num_entries != '0) begin
              state <= S_LOAD;
              idx   <= '0;
              cnt   <= num_entries > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : num_entries;
              busy  <= 1'b1;
            end
          S_LOAD: begin
            state      <= S_RUN;
            frequency  <= ent[FREQ_LSB +: FREQ_W];
            amplitude  <= ent[AMP_LSB +: AMP_W];
            duty_cycle <= ent[DUTY_LSB +: DUTY_W];
            cur_index  <= idx;
            on_rect    <= shape == SH_RECT;
            on_saw     <= shape == SH_SAW;
            on_tri     <= shape == SH_TRI;
            dwell      <= ent_dwell == '0 ? 16'd1 : ent_dwell;
          end
          S_RUN:
            if (tick) begin
              if (dwell == 16'd1) begin
                // Drop all enables for the LOAD gap so generator phases restart cleanly.
                on_rect <= 1'b0;
                on_saw  <= 1'b0;
                on_tri  <= 1'b0;
                if ({1'b0, idx} < cnt - (AW+1)'(1)) begin
                  idx   <= idx + AW'(1);
                  state <= S_LOAD;
                end else if (loop_en) begin
                  idx   <= '0;
                  state <= S_LOAD;
                end else begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                dwell <= dwell - 16'd1;
              end
            end
          default: state <= S_IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: scoreboard bench; the monitor turns DUT outputs into runs of constant output and checks them against queued expectations.
module tb_wave_sequencer;
  import wave_seq_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [49:0] wr_data = '0;
  logic [3:0]  num_entries = '0;
  logic        loop_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        on_rect, on_saw, on_tri, busy, done;
  logic [15:0] frequency;
  logic [7:0]  amplitude, duty_cycle;
  logic [2:0]  cur_index;
  logic [39:0] obs;
  int vectors = 0;
  int miscompares = 0;
  typedef struct packed {
    logic [2:0]  on;
    logic        busy;
    logic        done;
    logic [2:0]  idx;
    logic [15:0] f;
    logic [7:0]  a;
    logic [7:0]  d;
  } tup_t;
  typedef struct packed {
    tup_t        t;
    logic [31:0] len;
  } rec_t;
  rec_t exp_q[$];
  wave_sequencer #(.DEPTH(8), .CLK_PER_MS(10)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_entries(num_entries), .loop_en(loop_en), .start(start), .stop(stop),
    .on_rect(on_rect), .on_saw(on_saw), .on_tri(on_tri), .frequency(frequency),
    .amplitude(amplitude), .duty_cycle(duty_cycle), .cur_index(cur_index),
    .busy(busy), .done(done)
  );
  assign obs = {on_rect, on_saw, on_tri, busy, done, cur_index, frequency, amplitude, duty_cycle};
  always #5 clk = ~clk;
  function automatic logic [49:0] ent(input logic [1:0] sh, input logic [15:0] f,
                                      input logic [7:0] a, input logic [7:0] d, input logic [15:0] dw);
    return {sh, f, a, d, dw};
  endfunction
  function automatic string fmt(input rec_t r);
    return $sformatf("on=%b busy=%b done=%b idx=%0d f=%h a=%0d d=%0d len=%0d",
                     r.t.on, r.t.busy, r.t.done, r.t.idx, r.t.f, r.t.a, r.t.d, r.len);
  endfunction
  task automatic ex(input logic [2:0] on, input logic b, input logic dn, input logic [2:0] idx,
                    input logic [15:0] f, input logic [7:0] a, input logic [7:0] d, input int len);
    rec_t r;
    r.t.on = on; r.t.busy = b; r.t.done = dn; r.t.idx = idx;
    r.t.f = f; r.t.a = a; r.t.d = d; r.len = len;
    exp_q.push_back(r);
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask
  task automatic wr(input logic [2:0] addr, input logic [49:0] data);
    @(posedge clk); #1 wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask
  task automatic go(input logic [3:0] n);
    @(posedge clk); #1 num_entries = n; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected runs never seen, required 0 pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  // Monitor: a run is a stretch of cycles with an unchanged output tuple; idle runs are not checked.
  initial begin : monitor
    tup_t prev, cur;
    rec_t got, want;
    int len;
    prev = '0;
    len = 0;
    forever begin
      @(negedge clk);
      cur.on = {on_rect, on_saw, on_tri}; cur.busy = busy; cur.done = done; cur.idx = cur_index;
      cur.f = frequency; cur.a = amplitude; cur.d = duty_cycle;
      if (!rst_n) begin
        prev = cur;
        len = 0;
      end else begin
        if ($countones(cur.on) > 1) begin
          miscompares++;
          $display("FAIL onehot: got on=%b, required at most one bit set", cur.on);
        end
        if (cur != prev) begin
          if (len != 0 && (prev.busy || prev.done || prev.on != 3'b000)) begin
            got.t = prev;
            got.len = len;
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL run: got %s, required no run", fmt(got));
            end else begin
              want = exp_q.pop_front();
              if (got != want) begin
                miscompares++;
                $display("FAIL run: got %s, required %s", fmt(got), fmt(want));
              end
            end
          end
          len = 1;
        end else begin
          len++;
        end
        prev = cur;
      end
    end
  end
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish within 1 ms");
    $fatal(1, "watchdog");
  end
  initial begin : stim
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_outputs", 64'(obs), 64'd0);
    // Single RECT segment, no loop.
    wr(3'd0, ent(SH_RECT, 16'h00FF, 8'd50, 8'd25, 16'd3));
    ex(3'b000, 1, 0, 0, 16'h0000, 0, 0, 1);
    ex(3'b100, 1, 0, 0, 16'h00FF, 50, 25, 30);
    ex(3'b000, 0, 1, 0, 16'h00FF, 50, 25, 1);
    go(4'd1);
    drain("single_rect", 200);
    // Looping SAW / TRI / OFF, then stop during the second SAW.
    wr(3'd0, ent(SH_SAW, 16'h1234, 8'd10, 8'd20, 16'd2));
    wr(3'd1, ent(SH_TRI, 16'h0042, 8'd30, 8'd40, 16'd1));
    wr(3'd2, ent(SH_OFF, 16'h0007, 8'd5, 8'd6, 16'd1));
    loop_en = 1'b1;
    ex(3'b000, 1, 0, 0, 16'h00FF, 50, 25, 1);
    ex(3'b010, 1, 0, 0, 16'h1234, 10, 20, 20);
    ex(3'b000, 1, 0, 0, 16'h1234, 10, 20, 1);
    ex(3'b001, 1, 0, 1, 16'h0042, 30, 40, 10);
    ex(3'b000, 1, 0, 1, 16'h0042, 30, 40, 1);
    ex(3'b000, 1, 0, 2, 16'h0007, 5, 6, 11);
    go(4'd3);
    drain("loop_first_pass", 300);
    ex(3'b010, 1, 0, 0, 16'h1234, 10, 20, 7);
    repeat (5) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    chk("stop_idle", 64'({busy, on_rect, on_saw, on_tri, done}), 64'd0);
    drain("stop_mid_run", 20);
    // Simultaneous start+stop, and a zero-length start, both stay idle.
    @(posedge clk); #1 num_entries = 4'd1; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", 64'({busy, on_rect, on_saw, on_tri}), 64'd0);
    go(4'd0);
    chk("zero_entries_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    // 15 entries clamp to 8; a start (with new count) while busy is ignored.
    loop_en = 1'b0;
    ex(3'b000, 1, 0, 0, 16'h1234, 10, 20, 1);
    ex(3'b010, 1, 0, 0, 16'h1234, 10, 20, 20);
    ex(3'b000, 1, 0, 0, 16'h1234, 10, 20, 1);
    ex(3'b001, 1, 0, 1, 16'h0042, 30, 40, 10);
    ex(3'b000, 1, 0, 1, 16'h0042, 30, 40, 1);
    ex(3'b000, 1, 0, 2, 16'h0007, 5, 6, 11);
    for (int i = 3; i < 7; i++) ex(3'b000, 1, 0, 3'(i), 16'h0000, 0, 0, 11);
    ex(3'b000, 1, 0, 7, 16'h0000, 0, 0, 10);
    ex(3'b000, 0, 1, 7, 16'h0000, 0, 0, 1);
    go(4'd15);
    repeat (5) @(posedge clk);
    #1 num_entries = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain("clamp_depth", 400);
    // Table writes while running: entry1 mid-segment 0, entry0 on the loop-restart LOAD.
    loop_en = 1'b1;
    ex(3'b000, 1, 0, 7, 16'h0000, 0, 0, 1);
    go(4'd2);
    drain("wr_load", 100);
    ex(3'b010, 1, 0, 0, 16'h1234, 10, 20, 20);
    ex(3'b000, 1, 0, 0, 16'h1234, 10, 20, 1);
    wr(3'd1, ent(SH_RECT, 16'h0ABC, 8'd77, 8'd88, 16'd1));
    drain("wr_seg0", 100);
    ex(3'b100, 1, 0, 1, 16'h0ABC, 77, 88, 10);
    ex(3'b000, 1, 0, 1, 16'h0ABC, 77, 88, 1);
    repeat (9) @(posedge clk);
    #1 wr_en = 1'b1; wr_addr = 3'd0; wr_data = ent(SH_TRI, 16'h0555, 8'd11, 8'd22, 16'd1);
    @(posedge clk); #1 wr_en = 1'b0;
    ex(3'b010, 1, 0, 0, 16'h1234, 10, 20, 20);
    ex(3'b000, 1, 0, 0, 16'h1234, 10, 20, 1);
    ex(3'b100, 1, 0, 1, 16'h0ABC, 77, 88, 10);
    ex(3'b000, 1, 0, 1, 16'h0ABC, 77, 88, 1);
    drain("wr_restart", 200);
    ex(3'b001, 1, 0, 0, 16'h0555, 11, 22, 2);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    drain("wr_new_entry0", 20);
    // Asynchronous reset mid-RUN clears outputs and table.
    loop_en = 1'b0;
    ex(3'b000, 1, 0, 0, 16'h0555, 11, 22, 1);
    go(4'd1);
    drain("pre_reset_load", 100);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 64'(obs), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ex(3'b000, 1, 0, 0, 16'h0000, 0, 0, 11);
    ex(3'b000, 0, 1, 0, 16'h0000, 0, 0, 1);
    go(4'd1);
    drain("cleared_table", 100);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
